// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one fixed-latency memory port between two requesters (APB slave path and a second
//   master). One transaction is outstanding at a time. On a tie, the requester not served last
//   wins. Each address is range-checked against the memory window before any memory access.
//   Out-of-window requests complete immediately with err=1 and never reach the memory.
//
// Ports
//   PCLK, PRESETn         clock, asynchronous active-low reset
//   rN_req/addr/we/       requester N request (level, held until ack) and its
//   wdata/wstrb           write payload
//   rN_ack/rdata/err      one-cycle completion pulse; rdata/err hold until the next ack to N
//   mem_req_o             single-cycle memory request
//   mem_addr_o            window-local address (addr - BASE_ADDR)
//   mem_we_o/mem_wdata/   write enable, data and byte strobes, held from the latch
//   mem_wstrb
//   mem_rdata/mem_error_i read data and error, sampled MEM_LAT cycles after mem_req_o
module mem_port_arbiter #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned MEM_SIZE  = 32,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned MEM_LAT   = 1
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   // Requester 0
   input  logic                  r0_req,
   input  logic [ADDR_W-1:0]     r0_addr,
   input  logic                  r0_we,
   input  logic [DATA_W-1:0]     r0_wdata,
   input  logic [DATA_W/8-1:0]   r0_wstrb,
   output logic                  r0_ack,
   output logic [DATA_W-1:0]     r0_rdata,
   output logic                  r0_err,
   // Requester 1
   input  logic                  r1_req,
   input  logic [ADDR_W-1:0]     r1_addr,
   input  logic                  r1_we,
   input  logic [DATA_W-1:0]     r1_wdata,
   input  logic [DATA_W/8-1:0]   r1_wstrb,
   output logic                  r1_ack,
   output logic [DATA_W-1:0]     r1_rdata,
   output logic                  r1_err,
   // Memory port
   output logic                  mem_req_o,
   output logic [ADDR_W-1:0]     mem_addr_o,
   output logic                  mem_we_o,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_wstrb,
   input  logic [DATA_W-1:0]     mem_rdata,
   input  logic                  mem_error_i
);

   localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [ADDR_W-1:0] Base = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   Size = (ADDR_W + 1)'(MEM_SIZE);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e                     state_q;
   logic                       last_q;     // index of the requester served most recently
   logic                       idx_q;      // index of the requester owning the transaction
   logic [ADDR_W-1:0]          addr_q;
   logic                       we_q;
   logic [DATA_W-1:0]          wdata_q;
   logic [DATA_W/8-1:0]        wstrb_q;
   logic [CntW-1:0]            cnt_q;
   logic                       mem_req_q;
   logic [1:0]                 ack_q;
   logic [1:0][DATA_W-1:0]     rdata_q;
   logic [1:0]                 err_q;

   // Winner selection and window check on the request about to be latched
   logic                       win_idx;
   logic [ADDR_W-1:0]          win_addr;
   logic                       win_we;
   logic [DATA_W-1:0]          win_wdata;
   logic [DATA_W/8-1:0]        win_wstrb;
   logic [ADDR_W:0]            win_diff;
   logic                       win_in_range;

   always_comb begin
      // A lone requester wins outright; a tie goes to the one not served last.
      if (r0_req && r1_req) begin
         win_idx = ~last_q;
      end else begin
         win_idx = r1_req;
      end

      if (win_idx) begin
         win_addr  = r1_addr;
         win_we    = r1_we;
         win_wdata = r1_wdata;
         win_wstrb = r1_wstrb;
      end else begin
         win_addr  = r0_addr;
         win_we    = r0_we;
         win_wdata = r0_wdata;
         win_wstrb = r0_wstrb;
      end

      // One extra bit catches the borrow, so addresses below the base never wrap into range.
      win_diff     = {1'b0, win_addr} - {1'b0, Base};
      win_in_range = ~win_diff[ADDR_W] && ({1'b0, win_diff[ADDR_W-1:0]} < Size);
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q   <= StIdle;
         last_q    <= 1'b1;
         idx_q     <= 1'b0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         cnt_q     <= '0;
         mem_req_q <= 1'b0;
         ack_q     <= 2'b00;
         rdata_q   <= '0;
         err_q     <= 2'b00;
      end else begin
         // Pulse outputs default low; each is raised for exactly one state.
         mem_req_q <= 1'b0;
         ack_q     <= 2'b00;

         unique case (state_q)
            StIdle: begin
               if (r0_req || r1_req) begin
                  idx_q   <= win_idx;
                  last_q  <= win_idx;
                  addr_q  <= win_diff[ADDR_W-1:0];
                  we_q    <= win_we;
                  wdata_q <= win_wdata;
                  wstrb_q <= win_wstrb;
                  if (win_in_range) begin
                     state_q   <= StIssue;
                     mem_req_q <= 1'b1;
                  end else begin
                     // Out of window: answer straight away, memory never sees it.
                     state_q          <= StResp;
                     ack_q[win_idx]   <= 1'b1;
                     rdata_q[win_idx] <= '0;
                     err_q[win_idx]   <= 1'b1;
                  end
               end
            end

            StIssue: begin
               state_q <= StWait;
               cnt_q   <= CntW'(MEM_LAT - 1);
            end

            StWait: begin
               if (cnt_q == '0) begin
                  state_q        <= StResp;
                  ack_q[idx_q]   <= 1'b1;
                  rdata_q[idx_q] <= we_q ? '0 : mem_rdata;
                  err_q[idx_q]   <= mem_error_i;
               end else begin
                  cnt_q <= cnt_q - CntW'(1);
               end
            end

            StResp: begin
               // The following IDLE cycle re-arbitrates.
               state_q <= StIdle;
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign r0_ack     = ack_q[0];
   assign r0_rdata   = rdata_q[0];
   assign r0_err     = err_q[0];
   assign r1_ack     = ack_q[1];
   assign r1_rdata   = rdata_q[1];
   assign r1_err     = err_q[1];

   assign mem_req_o  = mem_req_q;
   assign mem_addr_o = addr_q;
   assign mem_we_o   = we_q;
   assign mem_wdata  = wdata_q;
   assign mem_wstrb  = wstrb_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. Instance 0: BASE_ADDR=0, MEM_LAT=1. Instance 1: BASE_ADDR=0x100,
// MEM_LAT=3. Stimulus pushes expected memory requests and acks (with their cycle numbers) into
// queues; a monitor pops and compares whenever a DUT raises mem_req_o or an ack.
module tb_mem_port_arbiter;

   typedef struct {
      int          g;
      int          who;
      int          cyc;
      logic [63:0] rdata;
      logic        err;
   } ack_exp_t;

   typedef struct {
      int          g;
      int          cyc;
      logic [31:0] addr;
      logic        we;
      logic [63:0] wdata;
      logic [7:0]  wstrb;
   } mem_exp_t;

   ack_exp_t ack_q [$];
   mem_exp_t memq  [$];
   int       total = 0;
   int       bad   = 0;
   int       cyc   = 0;

   logic        clk;
   logic        rstn   [2];
   logic        req    [2][2];
   logic [31:0] addr   [2][2];
   logic        we     [2][2];
   logic [63:0] wdata  [2][2];
   logic [7:0]  wstrb  [2][2];
   logic        ack    [2][2];
   logic [63:0] rdata  [2][2];
   logic        err    [2][2];
   logic        mreq   [2];
   logic [31:0] maddr  [2];
   logic        mwe    [2];
   logic [63:0] mwdata [2];
   logic [7:0]  mwstrb [2];
   logic        inj    [2];

   function automatic logic [31:0] base_of(input int g);
      return (g == 0) ? 32'h0 : 32'h100;
   endfunction

   function automatic int lat_of(input int g);
      return (g == 0) ? 1 : 3;
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int unsigned Base = (g == 0) ? 0 : 'h100;
      localparam int unsigned Lat  = (g == 0) ? 1 : 3;

      logic [63:0] mem [4];
      int          lat_cnt = 0;
      logic [63:0] mem_rd;
      logic        mem_er;

      mem_port_arbiter #(
         .ADDR_W   (32),
         .DATA_W   (64),
         .MEM_SIZE (32),
         .BASE_ADDR(Base),
         .MEM_LAT  (Lat)
      ) u_dut (
         .PCLK       (clk),
         .PRESETn    (rstn[g]),
         .r0_req     (req[g][0]),
         .r0_addr    (addr[g][0]),
         .r0_we      (we[g][0]),
         .r0_wdata   (wdata[g][0]),
         .r0_wstrb   (wstrb[g][0]),
         .r0_ack     (ack[g][0]),
         .r0_rdata   (rdata[g][0]),
         .r0_err     (err[g][0]),
         .r1_req     (req[g][1]),
         .r1_addr    (addr[g][1]),
         .r1_we      (we[g][1]),
         .r1_wdata   (wdata[g][1]),
         .r1_wstrb   (wstrb[g][1]),
         .r1_ack     (ack[g][1]),
         .r1_rdata   (rdata[g][1]),
         .r1_err     (err[g][1]),
         .mem_req_o  (mreq[g]),
         .mem_addr_o (maddr[g]),
         .mem_we_o   (mwe[g]),
         .mem_wdata  (mwdata[g]),
         .mem_wstrb  (mwstrb[g]),
         .mem_rdata  (mem_rd),
         .mem_error_i(mem_er)
      );

      initial begin
         for (int i = 0; i < 4; i++) mem[i] = 64'h1111_1111_1111_1111 * 64'(i + 1);
      end

      // Memory model: data is only valid on the exact latency cycle, poison otherwise.
      always @(posedge clk) begin
         if (mreq[g]) lat_cnt <= 1;
         else if (lat_cnt != 0) lat_cnt <= lat_cnt + 1;
         if (mreq[g] && mwe[g]) begin
            for (int b = 0; b < 8; b++) begin
               if (mwstrb[g][b]) mem[maddr[g][4:3]][8*b +: 8] <= mwdata[g][8*b +: 8];
            end
         end
      end

      assign mem_rd = (lat_cnt == int'(Lat)) ? mem[maddr[g][4:3]] : 64'hBAD0_BAD0_BAD0_BAD0;
      assign mem_er = inj[g] && (lat_cnt == int'(Lat));
   end

   // Monitor: every mem_req_o pulse and every ack must match the next expectation.
   always @(negedge clk) begin
      mem_exp_t em;
      ack_exp_t ea;
      for (int g = 0; g < 2; g++) begin
         if (mreq[g]) begin
            total++;
            if (memq.size() == 0) begin
               bad++;
               $display("FAIL mem_req inst%0d cyc=%0d: got unexpected pulse addr=%h, want none",
                        g, cyc, maddr[g]);
            end else begin
               em = memq.pop_front();
               if (em.g != g || em.cyc != cyc || maddr[g] != em.addr || mwe[g] != em.we ||
                   (em.we && (mwdata[g] != em.wdata || mwstrb[g] != em.wstrb))) begin
                  bad++;
                  $display("FAIL mem_req inst%0d cyc=%0d: got addr=%h we=%b wd=%h ws=%h, want inst%0d cyc=%0d addr=%h we=%b wd=%h ws=%h",
                           g, cyc, maddr[g], mwe[g], mwdata[g], mwstrb[g],
                           em.g, em.cyc, em.addr, em.we, em.wdata, em.wstrb);
               end
            end
         end
         for (int r = 0; r < 2; r++) begin
            if (ack[g][r]) begin
               total++;
               if (ack_q.size() == 0) begin
                  bad++;
                  $display("FAIL ack inst%0d r%0d cyc=%0d: got unexpected ack, want none",
                           g, r, cyc);
               end else begin
                  ea = ack_q.pop_front();
                  if (ea.g != g || ea.who != r || ea.cyc != cyc || rdata[g][r] != ea.rdata ||
                      err[g][r] != ea.err) begin
                     bad++;
                     $display("FAIL ack inst%0d r%0d cyc=%0d: got rdata=%h err=%b, want inst%0d r%0d cyc=%0d rdata=%h err=%b",
                              g, r, cyc, rdata[g][r], err[g][r],
                              ea.g, ea.who, ea.cyc, ea.rdata, ea.err);
                  end
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // One transaction from a lone requester, issued at a negedge with the DUT idle.
   task automatic xact(input int g, input int who, input logic [31:0] a, input logic w,
                       input logic [63:0] wd, input logic [7:0] ws,
                       input logic [63:0] exp_rd, input logic exp_err, input bit early_drop);
      int          c;
      int          ackc;
      logic [31:0] off;
      bit          inr;
      ack_exp_t    ea;
      mem_exp_t    em;
      c   = cyc;
      off = a - base_of(g);
      inr = (a >= base_of(g)) && (off < 32'd32);
      req[g][who]   = 1'b1;
      addr[g][who]  = a;
      we[g][who]    = w;
      wdata[g][who] = wd;
      wstrb[g][who] = ws;
      if (inr) begin
         em = '{g: g, cyc: c + 1, addr: off, we: w, wdata: wd, wstrb: ws};
         memq.push_back(em);
         ackc = c + lat_of(g) + 2;
         ea = '{g: g, who: who, cyc: ackc, rdata: exp_rd, err: exp_err};
      end else begin
         ackc = c + 1;
         ea = '{g: g, who: who, cyc: ackc, rdata: 64'd0, err: 1'b1};
      end
      ack_q.push_back(ea);
      if (early_drop) begin
         @(negedge clk);
         req[g][who] = 1'b0;
      end
      while (cyc < ackc) @(negedge clk);
      req[g][who] = 1'b0;
      @(negedge clk);
   endtask

   // Both requesters hold read requests for n transactions; grants alternate from 'first'.
   task automatic pair(input int g, input int n, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [63:0] d0, input logic [63:0] d1, input int first);
      int       c;
      int       p;
      int       who;
      ack_exp_t ea;
      mem_exp_t em;
      c = cyc;
      p = lat_of(g) + 3;
      for (int r = 0; r < 2; r++) begin
         req[g][r]   = 1'b1;
         addr[g][r]  = (r == 0) ? a0 : a1;
         we[g][r]    = 1'b0;
         wdata[g][r] = 64'd0;
         wstrb[g][r] = 8'd0;
      end
      for (int k = 0; k < n; k++) begin
         who = first ^ (k & 1);
         em = '{g: g, cyc: c + 1 + k * p, addr: ((who == 0) ? a0 : a1) - base_of(g),
                we: 1'b0, wdata: 64'd0, wstrb: 8'd0};
         memq.push_back(em);
         ea = '{g: g, who: who, cyc: c + lat_of(g) + 2 + k * p,
                rdata: (who == 0) ? d0 : d1, err: 1'b0};
         ack_q.push_back(ea);
      end
      while (cyc < c + lat_of(g) + 2 + (n - 1) * p) @(negedge clk);
      req[g][0] = 1'b0;
      req[g][1] = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by time limit, want finish");
      $fatal(1, "timeout");
   end

   initial begin
      int c;
      for (int g = 0; g < 2; g++) begin
         rstn[g] = 1'b1;
         inj[g]  = 1'b0;
         for (int r = 0; r < 2; r++) begin
            req[g][r]   = 1'b0;
            addr[g][r]  = '0;
            we[g][r]    = 1'b0;
            wdata[g][r] = '0;
            wstrb[g][r] = '0;
         end
      end
      #1;
      rstn[0] = 1'b0;
      rstn[1] = 1'b0;
      #1;
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("rst%0d_mem_req", g), 64'(mreq[g]), 64'd0);
         chk($sformatf("rst%0d_acks", g), 64'({ack[g][1], ack[g][0]}), 64'd0);
         chk($sformatf("rst%0d_errs", g), 64'({err[g][1], err[g][0]}), 64'd0);
         chk($sformatf("rst%0d_r0_rdata", g), rdata[g][0], 64'd0);
         chk($sformatf("rst%0d_mem_addr", g), 64'(maddr[g]), 64'd0);
      end
      repeat (2) @(negedge clk);
      rstn[0] = 1'b1;
      rstn[1] = 1'b1;
      @(negedge clk);

      // Instance 0: write, read back, partial-strobe write, contention, error, range.
      xact(0, 0, 32'h8, 1'b1, 64'hDEAD_BEEF_0000_0001, 8'hFF, 64'd0, 1'b0, 1'b0);
      xact(0, 1, 32'h8, 1'b0, 64'd0, 8'h00, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      chk("r1_rdata_hold", rdata[0][1], 64'hDEAD_BEEF_0000_0001);
      xact(0, 0, 32'h18, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 64'd0, 1'b0, 1'b0);
      xact(0, 1, 32'h18, 1'b0, 64'd0, 8'h00, 64'h4444_4444_CCCC_DDDD, 1'b0, 1'b0);
      pair(0, 4, 32'h8, 32'h10, 64'hDEAD_BEEF_0000_0001, 64'h3333_3333_3333_3333, 0);
      inj[0] = 1'b1;
      xact(0, 1, 32'h0, 1'b0, 64'd0, 8'h00, 64'h1111_1111_1111_1111, 1'b1, 1'b0);
      inj[0] = 1'b0;
      xact(0, 0, 32'h10, 1'b0, 64'd0, 8'h00, 64'h3333_3333_3333_3333, 1'b0, 1'b1);
      xact(0, 0, 32'h20, 1'b0, 64'd0, 8'h00, 64'd0, 1'b1, 1'b0);
      xact(0, 1, 32'hFFFF_FFF8, 1'b0, 64'd0, 8'h00, 64'd0, 1'b1, 1'b0);

      // Instance 1: window edges around BASE_ADDR=0x100.
      xact(1, 0, 32'h120, 1'b0, 64'd0, 8'h00, 64'd0, 1'b1, 1'b0);
      xact(1, 0, 32'hFF, 1'b0, 64'd0, 8'h00, 64'd0, 1'b1, 1'b0);
      xact(1, 0, 32'h11F, 1'b0, 64'd0, 8'h00, 64'h4444_4444_4444_4444, 1'b0, 1'b0);
      xact(1, 1, 32'h100, 1'b0, 64'd0, 8'h00, 64'h1111_1111_1111_1111, 1'b0, 1'b0);

      // Reset while in WAIT: request goes out, ack never comes.
      c = cyc;
      req[1][0]  = 1'b1;
      addr[1][0] = 32'h108;
      we[1][0]   = 1'b0;
      memq.push_back('{g: 1, cyc: c + 1, addr: 32'h8, we: 1'b0, wdata: 64'd0, wstrb: 8'd0});
      @(negedge clk);
      @(negedge clk);
      rstn[1] = 1'b0;
      #1;
      chk("midrst_mem_req", 64'(mreq[1]), 64'd0);
      chk("midrst_acks", 64'({ack[1][1], ack[1][0]}), 64'd0);
      chk("midrst_r0_rdata", rdata[1][0], 64'd0);
      chk("midrst_r1_rdata", rdata[1][1], 64'd0);
      chk("midrst_mem_addr", 64'(maddr[1]), 64'd0);
      req[1][0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rstn[1] = 1'b1;
      @(negedge clk);
      xact(1, 1, 32'h110, 1'b0, 64'd0, 8'h00, 64'h3333_3333_3333_3333, 1'b0, 1'b0);
      pair(1, 2, 32'h108, 32'h100, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111, 0);

      repeat (6) @(negedge clk);
      chk("ack_queue_drained", 64'(ack_q.size()), 64'd0);
      chk("mem_queue_drained", 64'(memq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
